// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the fetch PC and runs the imem req/ack handshake with redirects, stalls and timeout.
// Build option PC_MISALIGN_TRAP_EN: redirect targets with bit 1 set trap to ERR instead of being aligned.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] iaddr_in,
  input  logic        imem_ack_in,
  output logic        imem_req_out,
  output logic [31:0] iaddr_out,
  output logic [1:0]  pc_src_out,
  output logic        instr_valid_out,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic        timeout_out,
  output logic        misalign_out
);
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [1:0] SRC_RESET = 2'b00;
  localparam logic [1:0] SRC_NEXT  = 2'b11;

  typedef enum logic [1:0] {BOOT, REQ, STALL, ERR} state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc_q, pc_n, tgt_q, tgt_n, pc_out_n, target;
  logic [CW-1:0] wait_cnt, wait_n;
  logic          kill_q, kill_n, timeout_n, misalign_n, bad_target;
  logic          unused_addr_bits;

`ifdef PC_MISALIGN_TRAP_EN
  assign target     = {iaddr_in[31:1], 1'b0};
  assign bad_target = iaddr_in[1];
`else
  assign target     = {iaddr_in[31:2], 2'b00};
  assign bad_target = 1'b0;
`endif
  assign unused_addr_bits = ^iaddr_in[1:0];

  assign iaddr_out = pc_q;

  // State and registered outputs; req/pc_src follow the state being entered.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= BOOT;
      pc_q         <= RESET_VEC;
      tgt_q        <= RESET_VEC;
      kill_q       <= 1'b0;
      wait_cnt     <= '0;
      pc_out       <= RESET_VEC;
      imem_req_out <= 1'b0;
      pc_src_out   <= SRC_RESET;
      timeout_out  <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      state        <= state_n;
      pc_q         <= pc_n;
      tgt_q        <= tgt_n;
      kill_q       <= kill_n;
      wait_cnt     <= wait_n;
      pc_out       <= pc_out_n;
      imem_req_out <= (state_n == REQ);
      pc_src_out   <= (state_n == BOOT) ? SRC_RESET : SRC_NEXT;
      timeout_out  <= timeout_n;
      misalign_out <= misalign_n;
    end
  end

  // Next-state logic; priority is ERR > redirect > ack > stall.
  always_comb begin
    state_n         = state;
    pc_n            = pc_q;
    tgt_n           = tgt_q;
    kill_n          = kill_q;
    wait_n          = wait_cnt;
    pc_out_n        = pc_out;
    timeout_n       = timeout_out;
    misalign_n      = misalign_out;
    instr_valid_out = 1'b0;
    flush_out       = 1'b0;
    unique case (state)
      BOOT: begin
        pc_n    = RESET_VEC;
        state_n = stall_in ? STALL : REQ;
      end
      REQ: begin
        if (!imem_ack_in && (wait_cnt == WAIT_LAST)) begin
          state_n   = ERR;
          timeout_n = 1'b1;
          wait_n    = CW'(MAX_WAIT);
        end else if (branch_taken_in) begin
          flush_out = 1'b1;
          if (bad_target) begin
            state_n    = ERR;
            misalign_n = 1'b1;
          end else if (imem_ack_in) begin
            pc_n    = target;
            kill_n  = 1'b0;
            wait_n  = '0;
            state_n = stall_in ? STALL : REQ;
          end else begin
            // The raised request stays up; its response is dropped later.
            kill_n = 1'b1;
            tgt_n  = target;
            wait_n = wait_cnt + CW'(1);
          end
        end else if (imem_ack_in) begin
          if (kill_q) begin
            pc_n = tgt_q;
          end else begin
            instr_valid_out = 1'b1;
            pc_out_n        = pc_q;
            pc_n            = pc_q + AW'(4);
          end
          kill_n  = 1'b0;
          wait_n  = '0;
          state_n = stall_in ? STALL : REQ;
        end else begin
          wait_n = wait_cnt + CW'(1);
        end
      end
      STALL: begin
        if (branch_taken_in) begin
          flush_out = 1'b1;
          if (bad_target) begin
            state_n    = ERR;
            misalign_n = 1'b1;
          end else begin
            pc_n = target;
          end
        end else if (!stall_in) begin
          state_n = REQ;
        end
      end
      ERR: begin
        state_n = ERR;
      end
      default: state_n = ERR;
    endcase
  end
endmodule
